// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// rng_pkg : shared word width, capture FSM states and range-scaling helper
// Rev 1.0
// ============================================================================
package rng_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_ACK  = 1'b1
  } cap_state_e;

  // Upper half of word*range maps a uniform word onto 0..range-1; range 0 means raw.
  function automatic logic [WORD_W-1:0] scale_word(input logic [WORD_W-1:0] w,
                                                   input logic [WORD_W-1:0] r);
    logic [2*WORD_W-1:0] p;
    p = {{WORD_W{1'b0}}, w} * {{WORD_W{1'b0}}, r};
    return (r == '0) ? w : p[2*WORD_W-1:WORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rng_sfifo.sv
`default_nettype none
// ============================================================================
// rng_sfifo : synchronous first-word-fall-through FIFO with occupancy output
// Rev 1.0
// ============================================================================
module rng_sfifo
  import rng_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  // Head reads as zero when empty so reset leaves a defined output without clearing storage.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rng_prefetch.sv
`default_nettype none
// ============================================================================
// rng_prefetch : captures generator words into a FWFT FIFO, pulsing rng_start
//                once per accepted word. RNG_PREFETCH_RANGE_EN adds range scaling.
// Rev 1.0
// ============================================================================
module rng_prefetch
  import rng_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rng_valid,
  input  logic [WORD_W-1:0] rng_data,
`ifdef RNG_PREFETCH_RANGE_EN
  input  logic [WORD_W-1:0] range,
`endif
  output logic              rng_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [AW:0]       level
);

  cap_state_e        state_q, state_d;
  logic              push, pop, full, empty;
  logic [WORD_W-1:0] push_word;

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  // Registered pulse: high exactly while the FSM sits in ACK.
  assign rng_start = (state_q == ST_ACK);

`ifdef RNG_PREFETCH_RANGE_EN
  assign push_word = scale_word(rng_data, range);
`else
  assign push_word = rng_data;
`endif

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        // A same-cycle pop frees the slot, so a full FIFO can still accept.
        if (rng_valid && (!full || pop)) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  rng_sfifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule
`default_nettype wire

// File: tb/tb_rng_prefetch.sv
`default_nettype none
// ============================================================================
// tb_rng_prefetch : MT19937 generator model driving rng_prefetch, scoreboard on pops
// Rev 1.0
// ============================================================================
module tb_rng_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rng_valid;
  logic [31:0] rng_data;
  logic        rng_start;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  level;
  logic [31:0] rng_range;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_pop = 0;
  int gap_max = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mt [624];
  int          mti;

  always #5 clk = ~clk;

  rng_prefetch #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rng_valid (rng_valid),
    .rng_data  (rng_data),
`ifdef RNG_PREFETCH_RANGE_EN
    .range     (rng_range),
`endif
    .rng_start (rng_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mt_seed(input logic [31:0] s);
    mt[0] = s;
    for (int i = 1; i < 624; i++)
      mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
    mti = 624;
  endtask

  task automatic mt_next(output logic [31:0] y);
    if (mti >= 624) begin
      for (int k = 0; k < 624; k++) begin
        logic [31:0] x;
        x = (mt[k] & 32'h8000_0000) | (mt[(k+1)%624] & 32'h7fff_ffff);
        mt[k] = mt[(k+397)%624] ^ (x >> 1) ^ (x[0] ? 32'h9908_b0df : 32'h0);
      end
      mti = 0;
    end
    y = mt[mti];
    mti++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9d2c_5680);
    y = y ^ ((y << 15) & 32'hefc6_0000);
    y = y ^ (y >> 18);
  endtask

  function automatic logic [31:0] xform(input logic [31:0] w);
`ifdef RNG_PREFETCH_RANGE_EN
    logic [63:0] p;
    p = 64'(w) * 64'(rng_range);
    return (rng_range == 0) ? w : p[63:32];
`else
    return w;
`endif
  endfunction

  task automatic emit();
    logic [31:0] w;
    mt_next(w);
    rng_data  = w;
    rng_valid = 1'b1;
    exp_q.push_back(xform(w));
  endtask

  // Generator: holds each word until the start pulse, optionally idles before the next.
  initial begin
    bit start_prev;
    bit pending;
    int gap;
    rng_valid = 1'b0;
    rng_data  = '0;
    start_prev = 1'b0;
    pending = 1'b0;
    gap = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        exp_q.delete();
        mt_seed(32'd5489);
        emit();
        start_prev = 1'b0;
        pending = 1'b0;
      end else begin
        if (start_prev) begin
          rng_valid = 1'b0;
          gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
          pending = 1'b1;
        end
        if (pending) begin
          if (gap == 0) begin
            emit();
            pending = 1'b0;
          end else begin
            gap--;
          end
        end
        start_prev = rng_start;
      end
    end
  end

  // Pop monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        n_start = 0;
        n_pop = 0;
      end else begin
        if (rng_start) n_start++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_nonempty", 64'(exp_q.size()), 64'd1);
          end else begin
            check("sb_word", 64'(out_data), 64'(exp_q.pop_front()));
          end
`ifdef RNG_PREFETCH_RANGE_EN
          if (rng_range != 0) check("range_bound", 64'(out_data < rng_range), 64'd1);
`endif
          n_pop++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit ready);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    out_ready = ready;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !out_valid; i++) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    rst = 1'b1;
    out_ready = 1'b0;
    rng_range = '0;
    cyc(3);
    @(negedge clk);
    check("rst_start", 64'(rng_start), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_level", 64'(level),     64'd0);

    // First word arrives unrequested; out_valid one cycle after the push.
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("lat_valid0", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid1", 64'(out_valid), 64'd1);
    check("first_word", 64'(out_data), 64'd3499211612);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("second_word", 64'(out_data), 64'd581869302);

    // Fill to full and stall.
    for (int i = 0; i < 200 && level != 5'd16; i++) @(negedge clk);
    cyc(10);
    check("fill_level", 64'(level), 64'd16);
    s0 = n_start;
    cyc(10);
    check("full_no_start", 64'(n_start), 64'(s0));
    check("full_valid_held", 64'(rng_valid), 64'd1);
    check("start_eq_push", 64'(n_start), 64'(n_pop + level));
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("simul_full_level", 64'(level), 64'd16);
    cyc(5);
    check("one_more_start", 64'(n_start), 64'(s0 + 1));
    check("refill_level", 64'(level), 64'd16);
    check("start_eq_push2", 64'(n_start), 64'(n_pop + level));

    // Ready while empty is ignored; then stream 2000 words.
    do_reset(1'b1);
    @(negedge clk);
    check("empty_ready_level", 64'(level), 64'd0);
    check("empty_ready_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("empty_push_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 6000 && n_pop < 2000; i++) @(negedge clk);
    check("stream_pops", 64'(n_pop), 64'd2000);

    // Random backpressure and generator gaps.
    gap_max = 2;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1 out_ready = ($urandom_range(0, 2) != 0);
    end
    out_ready = 1'b0;
    gap_max = 0;
    cyc(80);
    check("rand_full_level", 64'(level), 64'd16);
    check("rand_start_eq_push", 64'(n_start), 64'(n_pop + level));

    // Reset during ACK suppresses the pulse and restarts the sequence.
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (rng_start) break;
    end
    check("saw_ack", 64'(rng_start), 64'd1);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ack_start", 64'(rng_start), 64'd0);
    check("rst_ack_level", 64'(level), 64'd0);
    check("rst_ack_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    wait_valid(20);
    check("restart_word", 64'(out_data), 64'd3499211612);

`ifdef RNG_PREFETCH_RANGE_EN
    rng_range = 32'd6;
    do_reset(1'b0);
    wait_valid(20);
    check("range_first", 64'(out_data), 64'd4);
    out_ready = 1'b1;
    cyc(300);
    rng_range = 32'd0;
    do_reset(1'b0);
    wait_valid(20);
    check("range_zero_raw", 64'(out_data), 64'd3499211612);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rng_prefetch.md
RNG_PREFETCH -- requirements
Module: rng_prefetch

Interface
REQ-001 Parameter: DEPTH, default 16, FIFO depth in words; power of two, 4..256.
REQ-002 Parameter: AW, default $clog2(DEPTH), FIFO pointer width.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rng_valid  input  1  generator word available; held high until a start pulse.
REQ-006 rng_data  input  32  generator word; stable while rng_valid=1.
REQ-007 rng_start  output  1  one-cycle pulse that acknowledges the current word and requests the next.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_data  output  32  head word, first-word-fall-through.
REQ-011 level  output  AW+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-012 Capture FSM states: WAIT, ACK.
- WAIT: if rng_valid=1 and the FIFO is not full (after this cycle's pop), push rng_data, go to ACK.
- ACK: rng_start=1 for exactly this cycle, no push, return to WAIT.
REQ-013 rng_start SHALL be a registered output, high only in ACK; a word SHALL be pushed exactly once even though rng_valid is still high during ACK.
REQ-014 The first word after reset SHALL be accepted without a prior rng_start, because the generator produces it unrequested.
REQ-015 Full FIFO: the FSM stays in WAIT, no rng_start, and the generator word is held; no word SHALL be dropped or duplicated.
REQ-016 Push-to-out_valid latency: out_valid SHALL rise on the cycle after the push into an empty FIFO.
REQ-017 Pop occurs when out_valid & out_ready; out_data SHALL show the next word on the following cycle.
REQ-018 Simultaneous push and pop SHALL leave level unchanged; push into a full FIFO is allowed only when a pop happens in the same cycle.
REQ-019 Pointers wrap modulo DEPTH; level SHALL equal pushes minus pops.
REQ-020 out_ready while out_valid=0 SHALL be ignored.
REQ-021 Words SHALL leave in generator order.

Reset
REQ-022 On rst: FSM to WAIT, pointers and level to 0, rng_start=0, out_valid=0, out_data=0.
REQ-023 rst mid-ACK SHALL suppress the pending start pulse; the generator is reset by the same rst.

Configuration
REQ-024 Macro RNG_PREFETCH_RANGE_EN adds input range (32 bits).
- Pushed value = upper 32 bits of rng_data*range; range=0 pushes rng_data unmodified.
- range SHALL be sampled at push time.
REQ-025 Without RNG_PREFETCH_RANGE_EN, the range port is absent and rng_data is stored raw.

Structure
REQ-026 Package rng_pkg SHALL hold WORD_W=32 and the capture FSM state enum.
REQ-027 Storage SHALL be the sub-module rng_sfifo: synchronous FWFT FIFO with DEPTH/AW parameters and push, pop, full, empty, and level ports.

Verification
REQ-028 Reset, generator SEED=5489, out_ready=0 -> first out_data=3499211612, second=581869302 after popping; rng_start count equals pushes.
REQ-029 out_ready=0 until full -> level=16, rng_start stops, rng_valid stays 1. Then pop one -> exactly one push and one start pulse, and level returns to 16.
REQ-030 out_ready=1 continuously -> no duplicated or skipped words against the MT19937 reference sequence for 2000 words.
REQ-031 Push and pop in the same cycle at level=16 and at level=0 -> level unchanged at 16, and level stays 0 with out_valid rising the next cycle.
REQ-032 rst asserted during ACK -> rng_start stays 0, level=0, and the sequence restarts at 3499211612.
REQ-033 RNG_PREFETCH_RANGE_EN, range=6 -> all outputs in 0..5, first value=(3499211612*6)>>32=4; range=0 -> raw words.
